// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage - FemtoRV32 decode stage and ID/EX pipeline register.
//
// Decodes the instruction held in IF/ID into control bits and a sign-extended
// immediate. Reads the 32x32 register file, which forwards same-cycle
// writebacks. Detects load-use hazards and drives stall back to fetch.
// Registers everything into the ID/EX pipeline register.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pc_ifid, instr_ifid, pc4_ifid IF/ID pipeline register contents
//   flush                         kill the instruction in ID (branch taken in EX)
//   wb_en, wb_rd, wb_data         register file write port
//   stall                         combinational; fetch holds PC and IF/ID
//   idex_*                        registered ID/EX pipeline register
//   stall_cnt                     hazard-bubble counter (only with ID_STALL_COUNT_EN)
//
// Optional feature macro: ID_STALL_COUNT_EN
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     pc_ifid,
  input  logic [31:0]     instr_ifid,
  input  logic [31:0]     pc4_ifid,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            idex_valid,
  output logic [31:0]     idex_pc,
  output logic [31:0]     idex_pc4,
  output logic [XLEN-1:0] idex_rs1_data,
  output logic [XLEN-1:0] idex_rs2_data,
  output logic [31:0]     idex_imm,
  output logic [4:0]      idex_rs1,
  output logic [4:0]      idex_rs2,
  output logic [4:0]      idex_rd,
  output logic [2:0]      idex_funct3,
  output logic            idex_funct7b5,
  output logic [8:0]      idex_ctrl,
`ifdef ID_STALL_COUNT_EN
  output logic [31:0]     stall_cnt,
`endif
  output logic            idex_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ctrl = {regwrite, memread, memwrite, memtoreg, alusrc, branch, jump, aluop[1:0]}
  localparam int CTRL_MEMREAD = 7;

  logic [XLEN-1:0] r_regs [NREGS];

  logic            r_valid;
  logic [31:0]     r_pc;
  logic [31:0]     r_pc4;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [31:0]     r_imm;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3;
  logic            r_funct7b5;
  logic [8:0]      r_ctrl;
  logic            r_illegal;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [8:0]      w_ctrl;
  logic            w_illegal;
  logic            w_uses_rs2;
  logic [31:0]     w_imm;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic            w_hazard;

  assign w_opcode = instr_ifid[6:0];
  assign w_rd     = instr_ifid[11:7];
  assign w_rs1    = instr_ifid[19:15];
  assign w_rs2    = instr_ifid[24:20];

  // Register file write port; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_en && (wb_rd != 5'd0)) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // Operand read with write-first forwarding of the writeback port.
  always_comb begin
    w_rs1_data = '0;
    w_rs2_data = '0;
    if (w_rs1 == 5'd0) begin
      w_rs1_data = '0;
    end else if (wb_en && (wb_rd == w_rs1)) begin
      w_rs1_data = wb_data;
    end else begin
      w_rs1_data = r_regs[w_rs1];
    end
    if (w_rs2 == 5'd0) begin
      w_rs2_data = '0;
    end else if (wb_en && (wb_rd == w_rs2)) begin
      w_rs2_data = wb_data;
    end else begin
      w_rs2_data = r_regs[w_rs2];
    end
  end

  // Opcode decode: control bits, immediate format and rs2 usage.
  always_comb begin
    w_ctrl      = 9'd0;
    w_illegal   = 1'b0;
    w_uses_rs2  = 1'b0;
    w_imm       = 32'd0;
    case (w_opcode)
      OP_R: begin
        w_ctrl     = 9'b1_0_0_0_0_0_0_10;
        w_uses_rs2 = 1'b1;
      end
      OP_I: begin
        w_ctrl = 9'b1_0_0_0_1_0_0_10;
        w_imm  = {{20{instr_ifid[31]}}, instr_ifid[31:20]};
      end
      OP_LOAD: begin
        w_ctrl = 9'b1_1_0_1_1_0_0_00;
        w_imm  = {{20{instr_ifid[31]}}, instr_ifid[31:20]};
      end
      OP_STORE: begin
        w_ctrl     = 9'b0_0_1_0_1_0_0_00;
        w_uses_rs2 = 1'b1;
        w_imm      = {{20{instr_ifid[31]}}, instr_ifid[31:25], instr_ifid[11:7]};
      end
      OP_BRANCH: begin
        w_ctrl     = 9'b0_0_0_0_0_1_0_01;
        w_uses_rs2 = 1'b1;
        w_imm      = {{19{instr_ifid[31]}}, instr_ifid[31], instr_ifid[7],
                      instr_ifid[30:25], instr_ifid[11:8], 1'b0};
      end
      OP_JAL: begin
        w_ctrl = 9'b1_0_0_0_0_0_1_00;
        w_imm  = {{11{instr_ifid[31]}}, instr_ifid[31], instr_ifid[19:12],
                  instr_ifid[20], instr_ifid[30:21], 1'b0};
      end
      OP_JALR: begin
        w_ctrl = 9'b1_0_0_0_1_0_1_00;
        w_imm  = {{20{instr_ifid[31]}}, instr_ifid[31:20]};
      end
      OP_LUI, OP_AUIPC: begin
        w_ctrl = 9'b1_0_0_0_1_0_0_11;
        w_imm  = {instr_ifid[31:12], 12'd0};
      end
      default: begin
        w_ctrl    = 9'd0;
        w_illegal = 1'b1;
      end
    endcase
  end

  // A load in EX whose destination feeds this instruction must wait one cycle.
  // rs1 is compared for every format; rs2 only where the field is a real source.
  assign w_hazard = r_valid && r_ctrl[CTRL_MEMREAD] && (r_rd != 5'd0) &&
                    ((r_rd == w_rs1) || (w_uses_rs2 && (r_rd == w_rs2)));

  // A flush discards the instruction anyway, so there is nothing to hold.
  assign stall = w_hazard && !flush;

  // ID/EX pipeline register: reset, flush and hazard all insert a zeroed bubble.
  always_ff @(posedge clk) begin
    if (rst || flush || w_hazard) begin
      r_valid    <= 1'b0;
      r_pc       <= 32'd0;
      r_pc4      <= 32'd0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= 32'd0;
      r_rs1      <= 5'd0;
      r_rs2      <= 5'd0;
      r_rd       <= 5'd0;
      r_funct3   <= 3'd0;
      r_funct7b5 <= 1'b0;
      r_ctrl     <= 9'd0;
      r_illegal  <= 1'b0;
    end else begin
      r_valid    <= 1'b1;
      r_pc       <= pc_ifid;
      r_pc4      <= pc4_ifid;
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_imm      <= w_imm;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rd       <= w_rd;
      r_funct3   <= instr_ifid[14:12];
      r_funct7b5 <= instr_ifid[30];
      r_ctrl     <= w_ctrl;
      r_illegal  <= w_illegal;
    end
  end

`ifdef ID_STALL_COUNT_EN
  logic [31:0] r_stall_cnt;

  // Count only hazard bubbles; flush bubbles are excluded. Wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
    end else if (w_hazard && !flush) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign idex_valid    = r_valid;
  assign idex_pc       = r_pc;
  assign idex_pc4      = r_pc4;
  assign idex_rs1_data = r_rs1_data;
  assign idex_rs2_data = r_rs2_data;
  assign idex_imm      = r_imm;
  assign idex_rs1      = r_rs1;
  assign idex_rs2      = r_rs2;
  assign idex_rd       = r_rd;
  assign idex_funct3   = r_funct3;
  assign idex_funct7b5 = r_funct7b5;
  assign idex_ctrl     = r_ctrl;
  assign idex_illegal  = r_illegal;

endmodule
